// File: rtl/sdio_data_xfer_ctrl.sv
// sdio_data_xfer_ctrl: sequences sdio_data_phy over whole CMD53-style transfers,
// one PHY activation per block, with write-CRC check, inter-block gap and watchdog.
// Ports: clk/rst (sync, active-high); i_start/i_write/i_block_mode/i_block_size/
// i_count/i_abort request side; o_busy/o_done/o_crc_err/o_timeout/o_aborted/
// o_blocks_done status; o_phy_* and i_phy_* connect to sdio_data_phy.
module sdio_data_xfer_ctrl #(
    parameter int unsigned GAP_CYCLES  = 4,
    parameter int unsigned WDOG_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_write,
    input  logic        i_block_mode,
    input  logic [11:0] i_block_size,
    input  logic [8:0]  i_count,
    input  logic        i_abort,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_crc_err,
    output logic        o_timeout,
    output logic        o_aborted,
    output logic [8:0]  o_blocks_done,
    output logic        o_phy_activate,
    output logic        o_phy_write_flag,
    output logic [12:0] o_phy_data_count,
    input  logic        i_phy_finished,
    input  logic        i_phy_crc_good
);

    typedef enum logic [2:0] {
        S_IDLE, S_ACTIVATE, S_WAIT_FIN, S_CHECK, S_GAP, S_DONE
    } state_t;

    // CHECK and ACTIVATE each contribute one low cycle to the gap,
    // so the GAP state itself only covers the remaining GAP_CYCLES-2.
    localparam logic [7:0]  GAP_LOAD = (GAP_CYCLES > 2) ? 8'(GAP_CYCLES - 3) : 8'd0;
    localparam logic        GAP_SKIP = (GAP_CYCLES <= 2);
    localparam logic [31:0] WDOG_LIM = 32'(WDOG_CYCLES);
    localparam logic        WDOG_EN  = (WDOG_CYCLES != 0);

    state_t      state_q;
    logic        write_q;
    logic        infinite_q;
    logic [8:0]  total_q;
    logic        crc_ok_q;
    logic [7:0]  gap_q;
    logic [31:0] wdog_q;
    logic        busy_q, done_q, crc_err_q, timeout_q, aborted_q;
    logic [8:0]  blocks_q;
    logic        act_q, wflag_q;
    logic [12:0] dcount_q;

    logic [8:0]  blocks_d;
    logic [31:0] wdog_d;
    logic        wdog_hit;
    logic        in_xfer;

    assign blocks_d = blocks_q + 9'd1;
    assign wdog_d   = wdog_q + 32'd1;
    assign wdog_hit = WDOG_EN && (wdog_d == WDOG_LIM);
    assign in_xfer  = (state_q != S_IDLE) && (state_q != S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            write_q    <= 1'b0;
            infinite_q <= 1'b0;
            total_q    <= '0;
            crc_ok_q   <= 1'b0;
            gap_q      <= '0;
            wdog_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            crc_err_q  <= 1'b0;
            timeout_q  <= 1'b0;
            aborted_q  <= 1'b0;
            blocks_q   <= '0;
            act_q      <= 1'b0;
            wflag_q    <= 1'b0;
            dcount_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (i_abort && in_xfer) begin
                // abort beats finish/timeout/CRC seen in the same cycle
                act_q     <= 1'b0;
                aborted_q <= 1'b1;
                done_q    <= 1'b1;
                busy_q    <= 1'b0;
                state_q   <= S_DONE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (i_start) begin
                            write_q    <= i_write;
                            wflag_q    <= i_write;
                            busy_q     <= 1'b1;
                            crc_err_q  <= 1'b0;
                            timeout_q  <= 1'b0;
                            aborted_q  <= 1'b0;
                            blocks_q   <= '0;
                            if (i_block_mode) begin
                                dcount_q   <= {1'b0, i_block_size};
                                total_q    <= i_count;
                                infinite_q <= (i_count == 9'd0);
                            end else begin
                                dcount_q   <= (i_count == 9'd0) ? 13'd512
                                                                : {4'b0000, i_count};
                                total_q    <= 9'd1;
                                infinite_q <= 1'b0;
                            end
                            state_q <= S_ACTIVATE;
                        end
                    end
                    S_ACTIVATE: begin
                        act_q   <= 1'b1;
                        wdog_q  <= '0;
                        state_q <= S_WAIT_FIN;
                    end
                    S_WAIT_FIN: begin
                        if (i_phy_finished) begin
                            // CRC status is only valid alongside finished
                            crc_ok_q <= i_phy_crc_good;
                            act_q    <= 1'b0;
                            state_q  <= S_CHECK;
                        end else begin
                            wdog_q <= wdog_d;
                            if (wdog_hit) begin
                                act_q     <= 1'b0;
                                timeout_q <= 1'b1;
                                done_q    <= 1'b1;
                                busy_q    <= 1'b0;
                                state_q   <= S_DONE;
                            end
                        end
                    end
                    S_CHECK: begin
                        if (write_q && !crc_ok_q) begin
                            crc_err_q <= 1'b1;
                            done_q    <= 1'b1;
                            busy_q    <= 1'b0;
                            state_q   <= S_DONE;
                        end else begin
                            blocks_q <= blocks_d;
                            if (!infinite_q && (blocks_d == total_q)) begin
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= S_DONE;
                            end else if (GAP_SKIP) begin
                                state_q <= S_ACTIVATE;
                            end else begin
                                gap_q   <= GAP_LOAD;
                                state_q <= S_GAP;
                            end
                        end
                    end
                    S_GAP: begin
                        if (gap_q == 8'd0) begin
                            state_q <= S_ACTIVATE;
                        end else begin
                            gap_q <= gap_q - 8'd1;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_busy           = busy_q;
    assign o_done           = done_q;
    assign o_crc_err        = crc_err_q;
    assign o_timeout        = timeout_q;
    assign o_aborted        = aborted_q;
    assign o_blocks_done    = blocks_q;
    assign o_phy_activate   = act_q;
    assign o_phy_write_flag = wflag_q;
    assign o_phy_data_count = dcount_q;

endmodule

// File: tb/tb_sdio_data_xfer_ctrl.sv
// tb_sdio_data_xfer_ctrl: directed bench for sdio_data_xfer_ctrl with a
// behavioural PHY responder and activation/gap monitor.
module tb_sdio_data_xfer_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_write = 1'b0;
    logic        i_block_mode = 1'b0;
    logic [11:0] i_block_size = '0;
    logic [8:0]  i_count = '0;
    logic        i_abort = 1'b0;
    logic        o_busy, o_done, o_crc_err, o_timeout, o_aborted;
    logic [8:0]  o_blocks_done;
    logic        o_phy_activate, o_phy_write_flag;
    logic [12:0] o_phy_data_count;
    logic        phy_fin = 1'b0;
    logic        phy_crc = 1'b1;

    sdio_data_xfer_ctrl #(
        .GAP_CYCLES  (4),
        .WDOG_CYCLES (100)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_start          (i_start),
        .i_write          (i_write),
        .i_block_mode     (i_block_mode),
        .i_block_size     (i_block_size),
        .i_count          (i_count),
        .i_abort          (i_abort),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_crc_err        (o_crc_err),
        .o_timeout        (o_timeout),
        .o_aborted        (o_aborted),
        .o_blocks_done    (o_blocks_done),
        .o_phy_activate   (o_phy_activate),
        .o_phy_write_flag (o_phy_write_flag),
        .o_phy_data_count (o_phy_data_count),
        .i_phy_finished   (phy_fin),
        .i_phy_crc_good   (phy_crc)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // PHY model / monitor state
    int          phy_lat = 5;
    int          crc_bad_blk = 0;
    bit          phy_mute = 1'b0;
    int          n_act = 0;
    int          min_gap = 999;
    int          max_gap = 0;
    int          low_run = 0;
    int          hi_cnt = 0;
    int          dc_bad = 0;
    bit          prev_act = 1'b0;
    logic [12:0] rise_dc = '0;
    logic        rise_wf = 1'b0;
    int          hi;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Sampled just after each rising edge so it never races the main
    // process, which works on falling edges.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (o_phy_activate) begin
                if (!prev_act) begin
                    n_act++;
                    if (n_act > 1) begin
                        if (low_run < min_gap) min_gap = low_run;
                        if (low_run > max_gap) max_gap = low_run;
                    end
                    low_run = 0;
                    hi_cnt  = 0;
                    rise_dc = o_phy_data_count;
                    rise_wf = o_phy_write_flag;
                end else if (o_phy_data_count !== rise_dc) begin
                    dc_bad++;
                end
                hi_cnt++;
                if (!phy_mute && hi_cnt == phy_lat) begin
                    phy_fin = 1'b1;
                    phy_crc = (n_act == crc_bad_blk) ? 1'b0 : 1'b1;
                end else begin
                    phy_fin = 1'b0;
                end
            end else begin
                phy_fin = 1'b0;
                hi_cnt  = 0;
                low_run++;
            end
            prev_act = o_phy_activate;
        end
    end

    task automatic start_xfer(input logic wr, input logic bm,
                              input logic [11:0] sz, input logic [8:0] cnt);
        n_act   = 0;
        min_gap = 999;
        max_gap = 0;
        dc_bad  = 0;
        i_write = wr;
        i_block_mode = bm;
        i_block_size = sz;
        i_count = cnt;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check("busy_rise", o_busy, 1);
        check("act_early", o_phy_activate, 0);
        @(negedge clk);
        check("act_rise", o_phy_activate, 1);
    endtask

    task automatic wait_done(output int hcnt);
        hcnt = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (o_done) begin
                check("busy_at_done", o_busy, 0);
                @(negedge clk);
                check("done_pulse", o_done, 0);
                return;
            end
            if (o_phy_activate) hcnt++;
        end
        check("done_seen", o_done, 1);
    endtask

    initial begin
        // reset
        repeat (3) @(negedge clk);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_flags", {o_crc_err, o_timeout, o_aborted}, 0);
        check("rst_blocks", o_blocks_done, 0);
        check("rst_act", o_phy_activate, 0);
        check("rst_dc", {o_phy_write_flag, o_phy_data_count}, 0);
        rst = 1'b0;
        @(negedge clk);

        // byte-mode write, 8 bytes
        phy_lat = 5;
        start_xfer(1'b1, 1'b0, 12'd100, 9'd8);
        wait_done(hi);
        check("t1_nact", n_act, 1);
        check("t1_dc", rise_dc, 8);
        check("t1_wf", rise_wf, 1);
        check("t1_flags", {o_crc_err, o_timeout, o_aborted}, 0);
        check("t1_blocks", o_blocks_done, 1);

        // abort while idle is ignored
        i_abort = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_abort_busy", o_busy, 0);
        check("idle_abort_flag", o_aborted, 0);
        i_abort = 1'b0;
        @(negedge clk);

        // block-mode read, 3 x 64
        start_xfer(1'b0, 1'b1, 12'd64, 9'd3);
        wait_done(hi);
        check("t2_nact", n_act, 3);
        check("t2_dc", rise_dc, 64);
        check("t2_wf", rise_wf, 0);
        check("t2_gap_min", min_gap, 4);
        check("t2_gap_max", max_gap, 4);
        check("t2_dc_stable", dc_bad, 0);
        check("t2_blocks", o_blocks_done, 3);
        check("t2_flags", {o_crc_err, o_timeout, o_aborted}, 0);

        // write CRC failure on block 2 of 4
        crc_bad_blk = 2;
        start_xfer(1'b1, 1'b1, 12'd512, 9'd4);
        wait_done(hi);
        check("t3_crc", o_crc_err, 1);
        check("t3_blocks", o_blocks_done, 1);
        check("t3_other", {o_timeout, o_aborted}, 0);
        repeat (20) @(negedge clk);
        check("t3_nact", n_act, 2);
        crc_bad_blk = 0;

        // infinite block mode, abort during 5th block
        start_xfer(1'b0, 1'b1, 12'd16, 9'd0);
        for (int i = 0; i < 500; i++) begin
            if (n_act == 5) break;
            @(negedge clk);
        end
        check("t4_reach5", n_act, 5);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        check("t4_act", o_phy_activate, 0);
        check("t4_done", o_done, 1);
        check("t4_busy", o_busy, 0);
        check("t4_abort", o_aborted, 1);
        check("t4_other", {o_crc_err, o_timeout}, 0);
        check("t4_blocks", o_blocks_done, 4);
        @(negedge clk);
        check("t4_done_pulse", o_done, 0);

        // watchdog: PHY never finishes
        phy_mute = 1'b1;
        start_xfer(1'b1, 1'b0, 12'd0, 9'd4);
        wait_done(hi);
        check("t5_wdog_lat", 1 + hi, 100);
        check("t5_timeout", o_timeout, 1);
        check("t5_other", {o_crc_err, o_aborted}, 0);
        check("t5_blocks", o_blocks_done, 0);
        check("t5_act", o_phy_activate, 0);
        phy_mute = 1'b0;

        // byte mode count 0 => 512, extra start while busy ignored
        phy_lat = 20;
        start_xfer(1'b0, 1'b0, 12'd7, 9'd0);
        repeat (3) @(negedge clk);
        i_block_mode = 1'b1;
        i_count = 9'd3;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        wait_done(hi);
        check("t6_dc", rise_dc, 512);
        check("t6_nact", n_act, 1);
        check("t6_blocks", o_blocks_done, 1);
        repeat (30) @(negedge clk);
        check("t6_nact_after", n_act, 1);
        check("t6_busy_after", o_busy, 0);
        check("t6_blocks_after", o_blocks_done, 1);

        // reset in mid-transfer
        phy_lat = 50;
        start_xfer(1'b1, 1'b0, 12'd0, 9'd8);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t7_act", o_phy_activate, 0);
        check("t7_busy", o_busy, 0);
        check("t7_dc", {o_phy_write_flag, o_phy_data_count}, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("t7_idle", {o_busy, o_phy_activate}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
